// File: rtl/jtag_tdr_csr_seq_if.sv
// Requester-side bus of the TDR CSR sequencer.
//   req        level request per requester, held until ack
//   req_wr     1=write, 0=read, per requester
//   req_addr   28-bit CSR address, requester i at [28*i +: 28]
//   req_wdata  16-bit write data, requester i at [16*i +: 16]
//   ack        one-cycle completion pulse to the granted requester
//   rdata      read data, valid in the ack cycle of a read
//   busy       high from grant through the ack cycle
// master: requester side; slave: sequencer side.
interface jtag_tdr_csr_seq_if #(
  parameter int unsigned NUM_REQ = 2
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    req_wr;
  logic [NUM_REQ*28-1:0] req_addr;
  logic [NUM_REQ*16-1:0] req_wdata;
  logic [NUM_REQ-1:0]    ack;
  logic [15:0]           rdata;
  logic                  busy;

  modport master (
    output req, req_wr, req_addr, req_wdata,
    input  ack, rdata, busy
  );

  modport slave (
    input  req, req_wr, req_addr, req_wdata,
    output ack, rdata, busy
  );
endinterface

// File: rtl/jtag_tdr_csr_seq.sv
// CSR access sequencer for the DdrPhyCsrCmdTdr / DdrPhyCsrRdDataTdr chains.
// Arbitrates NUM_REQ requesters, serialises the granted request into a 45-bit command
// TDR capture/shift/update sequence and, for reads, collects 16 bits from the read-data
// TDR and returns them in parallel.
//
// Ports:
//   TDRCLK, WRSTN            TDR clock (rising edge) and async active-low reset
//   bus (slave)              requester bus: req/req_wr/req_addr/req_wdata in,
//                            ack/rdata/busy out
//   DdrPhyCsrCmdTdr*En       command TDR capture/shift/update enables
//   DdrPhyCsrRdDataTdr*En    read-data TDR capture/shift/update enables
//   WSI                      serial data into the command TDR, LSB first
//   DdrPhyCsrRdDataTdr_Tdo   serial data out of the read-data TDR
//
// Configuration macro JTAG_TDR_RR_ARB_EN: when defined, round-robin arbitration starting
// after the last granted requester; otherwise fixed priority, lowest index wins.
//
// All outputs come straight from flops; their next values are decoded from the next state.
module jtag_tdr_csr_seq #(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned RD_WAIT_CYC = 30,
  parameter int unsigned RD_GAP_CYC  = 12
) (
  input  logic              TDRCLK,
  input  logic              WRSTN,
  jtag_tdr_csr_seq_if.slave bus,
  output logic              DdrPhyCsrCmdTdrCaptureEn,
  output logic              DdrPhyCsrCmdTdrShiftEn,
  output logic              DdrPhyCsrCmdTdrUpdateEn,
  output logic              DdrPhyCsrRdDataTdrCaptureEn,
  output logic              DdrPhyCsrRdDataTdrShiftEn,
  output logic              DdrPhyCsrRdDataTdrUpdateEn,
  output logic              WSI,
  input  logic              DdrPhyCsrRdDataTdr_Tdo
);

  localparam int unsigned CmdW    = 45;
  localparam int unsigned GntW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntMax0 = (RD_WAIT_CYC > CmdW) ? RD_WAIT_CYC : CmdW;
  localparam int unsigned CntMax  = (RD_GAP_CYC > CntMax0) ? RD_GAP_CYC : CntMax0;
  localparam int unsigned CntW    = $clog2(CntMax);

  localparam logic [CntW-1:0] CmdLast  = CntW'(CmdW - 1);
  localparam logic [CntW-1:0] WaitLast = CntW'(RD_WAIT_CYC - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(RD_GAP_CYC - 1);
  localparam logic [CntW-1:0] RdLast   = CntW'(15);

  typedef enum logic [3:0] {
    StIdle,
    StCmdCap,
    StCmdGap,
    StCmdShift,
    StCmdPost,
    StCmdUpd,
    StRdWait,
    StRdCap,
    StRdGap,
    StRdShift,
    StRdUpd,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [GntW-1:0]     grant_q, grant_d;
  logic [CmdW-1:0]     cmd_q, cmd_d;
  logic [15:0]         rd_sh_q, rd_sh_d;
  logic [15:0]         rdata_q, rdata_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                busy_q, busy_d;
  logic                cmd_cap_q, cmd_cap_d;
  logic                cmd_shift_q, cmd_shift_d;
  logic                cmd_upd_q, cmd_upd_d;
  logic                rd_cap_q, rd_cap_d;
  logic                rd_shift_q, rd_shift_d;
  logic                rd_upd_q, rd_upd_d;
  logic                wsi_q, wsi_d;

  // ---------------------------------------------------------------------------------------
  // Requester unpacking and arbitration
  // ---------------------------------------------------------------------------------------
  logic [27:0]     addr_arr  [NUM_REQ];
  logic [15:0]     wdata_arr [NUM_REQ];
  logic [GntW-1:0] arb_idx;
  logic            grant_fire;
  logic            sel_wr;
  logic [CmdW-1:0] new_cmd;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = bus.req_addr[28*g +: 28];
    assign wdata_arr[g] = bus.req_wdata[16*g +: 16];
  end

  assign grant_fire = (state_q == StIdle) && (|bus.req);

`ifdef JTAG_TDR_RR_ARB_EN
  logic [GntW-1:0] last_grant_q;
  int unsigned     rr_cand;
  logic            rr_found;

  // Search from the requester after the last grant, wrapping modulo NUM_REQ.
  always_comb begin
    arb_idx  = last_grant_q;
    rr_cand  = 0;
    rr_found = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      rr_cand = (32'(last_grant_q) + k) % NUM_REQ;
      if (!rr_found && bus.req[GntW'(rr_cand)]) begin
        arb_idx  = GntW'(rr_cand);
        rr_found = 1'b1;
      end
    end
  end

  always_ff @(posedge TDRCLK or negedge WRSTN) begin
    if (!WRSTN) begin
      last_grant_q <= GntW'(NUM_REQ - 1);
    end else if (grant_fire) begin
      last_grant_q <= arb_idx;
    end
  end
`else
  // Fixed priority: scanning downwards leaves the lowest active index in arb_idx.
  always_comb begin
    arb_idx = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (bus.req[i]) arb_idx = GntW'(i);
    end
  end
`endif

  assign sel_wr  = bus.req_wr[arb_idx];
  assign new_cmd = sel_wr ? {wdata_arr[arb_idx], 1'b1, addr_arr[arb_idx]}
                          : {16'h0000, 1'b0, addr_arr[arb_idx]};

  // ---------------------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    cmd_d   = cmd_q;
    rd_sh_d = rd_sh_q;
    rdata_d = rdata_q;

    unique case (state_q)
      StIdle: begin
        if (grant_fire) begin
          state_d = StCmdCap;
          grant_d = arb_idx;
          cmd_d   = new_cmd;
        end
      end
      StCmdCap: state_d = StCmdGap;
      StCmdGap: begin
        state_d = StCmdShift;
        cnt_d   = '0;
      end
      StCmdShift: begin
        if (cnt_q == CmdLast) begin
          state_d = StCmdPost;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StCmdPost: state_d = StCmdUpd;
      // cmd bit 28 is the write flag: writes finish here, reads fetch data.
      StCmdUpd: begin
        state_d = cmd_q[28] ? StDone : StRdWait;
        cnt_d   = '0;
      end
      StRdWait: begin
        if (cnt_q == WaitLast) begin
          state_d = StRdCap;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRdCap: begin
        state_d = StRdGap;
        cnt_d   = '0;
      end
      StRdGap: begin
        if (cnt_q == GapLast) begin
          state_d = StRdShift;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRdShift: begin
        // Bit cnt of the word is sampled at the edge that ends shift cycle cnt.
        rd_sh_d[cnt_q[3:0]] = DdrPhyCsrRdDataTdr_Tdo;
        if (cnt_q == RdLast) begin
          state_d = StRdUpd;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRdUpd: begin
        // Publish the assembled word so rdata only changes when a read completes.
        state_d = StDone;
        rdata_d = rd_sh_q;
      end
      StDone: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------------------
  // Registered outputs, decoded from the next state
  // ---------------------------------------------------------------------------------------
  always_comb begin
    cmd_cap_d   = (state_d == StCmdCap);
    cmd_shift_d = (state_d == StCmdShift);
    cmd_upd_d   = (state_d == StCmdUpd);
    rd_cap_d    = (state_d == StRdCap);
    rd_shift_d  = (state_d == StRdShift);
    rd_upd_d    = (state_d == StRdUpd);
    busy_d      = (state_d != StIdle);

    ack_d = '0;
    if (state_d == StDone) ack_d[grant_d] = 1'b1;

    // WSI presents cmd[0] ahead of the shift and holds its last value outside it.
    wsi_d = wsi_q;
    if ((state_d == StCmdCap) || (state_d == StCmdGap)) begin
      wsi_d = cmd_d[0];
    end else if (state_d == StCmdShift) begin
      wsi_d = cmd_d[cnt_d[5:0]];
    end
  end

  always_ff @(posedge TDRCLK or negedge WRSTN) begin
    if (!WRSTN) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      grant_q     <= '0;
      cmd_q       <= '0;
      rd_sh_q     <= '0;
      rdata_q     <= '0;
      ack_q       <= '0;
      busy_q      <= 1'b0;
      cmd_cap_q   <= 1'b0;
      cmd_shift_q <= 1'b0;
      cmd_upd_q   <= 1'b0;
      rd_cap_q    <= 1'b0;
      rd_shift_q  <= 1'b0;
      rd_upd_q    <= 1'b0;
      wsi_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      cmd_q       <= cmd_d;
      rd_sh_q     <= rd_sh_d;
      rdata_q     <= rdata_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      cmd_cap_q   <= cmd_cap_d;
      cmd_shift_q <= cmd_shift_d;
      cmd_upd_q   <= cmd_upd_d;
      rd_cap_q    <= rd_cap_d;
      rd_shift_q  <= rd_shift_d;
      rd_upd_q    <= rd_upd_d;
      wsi_q       <= wsi_d;
    end
  end

  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;
  assign bus.busy  = busy_q;

  assign DdrPhyCsrCmdTdrCaptureEn    = cmd_cap_q;
  assign DdrPhyCsrCmdTdrShiftEn      = cmd_shift_q;
  assign DdrPhyCsrCmdTdrUpdateEn     = cmd_upd_q;
  assign DdrPhyCsrRdDataTdrCaptureEn = rd_cap_q;
  assign DdrPhyCsrRdDataTdrShiftEn   = rd_shift_q;
  assign DdrPhyCsrRdDataTdrUpdateEn  = rd_upd_q;
  assign WSI                         = wsi_q;

endmodule
